mna_response: RTL

//  Response-side master network adapter: receives response packets (header/body/tail flits)

---
 rtl/mna_response_if.sv | 24 ++
 rtl/mna_response.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mna_response_if.sv
// AXI4-Lite response channels (R and B) between the response network adapter
// and the AXI master it serves.
//   rdata/rresp/rvalid/rready : read response channel
//   bresp/bvalid/bready       : write response channel
// The slave modport drives the responses; the master modport accepts them.
interface mna_response_if;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    input  rdata, rresp, rvalid, bresp, bvalid,
    output rready, bready
  );

  modport slave (
    output rdata, rresp, rvalid, bresp, bvalid,
    input  rready, bready
  );
endinterface

// File: rtl/mna_response.sv
// Response-side master network adapter. Collects one response packet
// (header, optional body, tail) from the NoC and presents it to the AXI
// master as an R or B response. Flow control is on/off per virtual channel.
// Only one packet is in flight at a time.
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   noc_data     flit: [33:32] type (01 hdr, 00 body, 10 tail, 11 illegal), [31:0] payload
//   is_valid     noc_data/noc_vc valid
//   noc_vc       one-hot VC of the incoming flit
//   is_on_off    per-VC accept enable
//   axi          R/B response channels (slave side)
//   err_drop     pulse: flit dropped (illegal or out of sequence)
//   err_timeout  pulse: partial packet aborted after TIMEOUT idle cycles
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no packet open, every VC enabled, waiting for a header
// WAIT_BODY | read header seen, waiting for the data body on locked VC
// WAIT_TAIL | waiting for the tail on locked VC
// RESP_R    | read response presented, waiting for rready
// RESP_B    | write response presented, waiting for bready
module mna_response #(
  parameter int TIMEOUT = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [33:0]   noc_data,
  input  logic          is_valid,
  input  logic [7:0]    noc_vc,
  output logic [7:0]    is_on_off,
  mna_response_if.slave axi,
  output logic          err_drop,
  output logic          err_timeout
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BODY = 3'd1,
    WAIT_TAIL = 3'd2,
    RESP_R    = 3'd3,
    RESP_B    = 3'd4
  } state_t;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HDR  = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;

  // Keep at least one bit so TIMEOUT=0 (timeout disabled) still elaborates.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t          state_q, state_d;
  logic [7:0]      vc_q, vc_d;
  logic            wr_q, wr_d;
  logic [1:0]      resp_q, resp_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_drop_d, err_timeout_d;

  logic            vc_onehot;
  logic            accept;
  logic            waiting;
  logic            expire;
  logic [1:0]      ftype;
  logic [31:0]     payload;

  assign ftype   = noc_data[33:32];
  assign payload = noc_data[31:0];

  always_comb begin
    case (state_q)
      IDLE:                 is_on_off = 8'hFF;
      WAIT_BODY, WAIT_TAIL: is_on_off = vc_q;
      default:              is_on_off = 8'h00;
    endcase
  end

  assign vc_onehot = (noc_vc != 8'd0) && ((noc_vc & (noc_vc - 8'd1)) == 8'd0);
  assign accept    = is_valid && vc_onehot && ((noc_vc & is_on_off) != 8'd0);
  assign waiting   = (state_q == WAIT_BODY) || (state_q == WAIT_TAIL);

  // Expiry happens on the TIMEOUT-th consecutive idle cycle; a flit accepted
  // in that same cycle takes precedence.
  assign expire = (TIMEOUT > 0) && waiting && !accept &&
                  (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    vc_d          = vc_q;
    wr_d          = wr_q;
    resp_d        = resp_q;
    rdata_d       = rdata_q;
    cnt_d         = '0;
    err_drop_d    = 1'b0;
    err_timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ftype == T_HDR) begin
            resp_d  = payload[1:0];
            wr_d    = payload[31];
            vc_d    = noc_vc;
            state_d = payload[31] ? WAIT_TAIL : WAIT_BODY;
          end else begin
            err_drop_d = 1'b1;
          end
        end
      end
      WAIT_BODY: begin
        if (accept) begin
          case (ftype)
            T_BODY: begin
              rdata_d = payload;
              state_d = WAIT_TAIL;
            end
            T_TAIL: begin
              // Read packet without data: discard it entirely.
              err_drop_d = 1'b1;
              state_d    = IDLE;
            end
            default: err_drop_d = 1'b1;
          endcase
        end
      end
      WAIT_TAIL: begin
        if (accept) begin
          if (ftype == T_TAIL) begin
            state_d = wr_q ? RESP_B : RESP_R;
          end else begin
            err_drop_d = 1'b1;
          end
        end
      end
      RESP_R: begin
        if (axi.rready) state_d = IDLE;
      end
      RESP_B: begin
        if (axi.bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (waiting && !accept) begin
      if (expire) begin
        state_d       = IDLE;
        err_timeout_d = 1'b1;
      end else if (TIMEOUT > 0) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (state_d == IDLE) vc_d = 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vc_q        <= 8'h00;
      wr_q        <= 1'b0;
      resp_q      <= 2'b00;
      rdata_q     <= 32'h0;
      cnt_q       <= '0;
      err_drop    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      vc_q        <= vc_d;
      wr_q        <= wr_d;
      resp_q      <= resp_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      err_drop    <= err_drop_d;
      err_timeout <= err_timeout_d;
    end
  end

  assign axi.rvalid = (state_q == RESP_R);
  assign axi.bvalid = (state_q == RESP_B);
  assign axi.rdata  = rdata_q;
  assign axi.rresp  = resp_q;
  assign axi.bresp  = resp_q;

endmodule
